// File: rtl/jpeg_stream_sequencer_pkg.sv
// Shared definitions for the JPEG output-path sequencer.
//   seq_state_e  : frame-level FSM states
//   shadow_t     : one shadow-FIFO entry (per-lane no-stuff mask + EOI flag)
//   EOI_WORD     : fill bytes followed by the EOI marker, enqueued last in a frame
//   FILL_BYTE    : padding byte; also the value that triggers a stuffed 0x00
//   SHADOW_DEPTH : entries in the shadow FIFO (matches the stuffer lane depth)
package jpeg_stream_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_ENT,
      ST_EOI,
      ST_DRAIN
   } seq_state_e;

   localparam logic [31:0] EOI_WORD     = 32'hFFFF_FFD9;
   localparam logic [7:0]  FILL_BYTE    = 8'hFF;
   localparam int unsigned SHADOW_DEPTH = 32;
   localparam int unsigned SHADOW_AW    = $clog2(SHADOW_DEPTH);

   // mask[i] covers byte lane i; lane 0 is bits [31:24].
   typedef struct packed {
      logic       eoi;
      logic [3:0] mask;
   } shadow_t;

   // Widen a 4-bit lane mask to the stuffer's 32-bit per-byte no-stuff mask.
   function automatic logic [31:0] expand_mask(input logic [3:0] mask);
      logic [31:0] res;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         res[31-8*i -: 8] = {8{mask[i]}};
      end
      return res;
   endfunction

endpackage

// File: rtl/jpeg_stream_sequencer_mask_fifo.sv
// Shadow FIFO mirroring the words held inside the byte stuffer.
// One entry is pushed per enqueued word and popped when that word retires.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push     : write wdata at the tail
//   pop      : drop the head entry
//   rdata    : head entry (show-ahead, valid whenever !empty)
//   empty    : no entries held
module mask_fifo
   import jpeg_stream_sequencer_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  shadow_t wdata,
   input  logic    pop,
   output shadow_t rdata,
   output logic    empty
);

   logic [SHADOW_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [SHADOW_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [SHADOW_AW:0]   count_q,  count_d;
   shadow_t              mem [SHADOW_DEPTH];

   // NOTE: every variable assigned in always_comb gets a value on every path
   // (here unconditionally), otherwise synthesis infers a latch.
   always_comb begin
      // Pointers are exactly SHADOW_AW bits wide, so they wrap at the depth.
      wr_ptr_d = wr_ptr_q + SHADOW_AW'(push);
      rd_ptr_d = rd_ptr_q + SHADOW_AW'(pop);
      count_d  = count_q + (SHADOW_AW+1)'(push) - (SHADOW_AW+1)'(pop);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers alone
   // decide which entries are meaningful, and this keeps it a plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem[rd_ptr_q];
   assign empty = (count_q == '0);

endmodule

// File: rtl/jpeg_stream_sequencer.sv
// Frame-level controller for the JPEG output path around the insert_stuff stage.
// Per frame: header words from an external ROM (no stuffing), entropy words
// (stuffing enabled, partial last word padded with 0xFF), then the EOI word.
// The stuffed byte stream is passed to a valid/ready sink. A word credit
// counter keeps the stuffer (which has no enqueue back-pressure) from overflowing.
//   frame_start/busy/frame_done : frame control
//   hdr_addr/hdr_data           : header ROM, data one cycle after address
//   ent_*                       : entropy word handshake
//   st_*                        : stuffer enqueue/dequeue side
//   out_*                       : byte sink handshake
module jpeg_stream_sequencer
   import jpeg_stream_sequencer_pkg::*;
#(
   parameter int unsigned HDR_WORDS = 156,
   parameter int unsigned HDR_AW    = 8,
   parameter int unsigned CREDITS   = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_start,
   output logic              busy,
   output logic              frame_done,
   output logic [HDR_AW-1:0] hdr_addr,
   input  logic [31:0]       hdr_data,
   input  logic              ent_valid,
   output logic              ent_ready,
   input  logic [31:0]       ent_data,
   input  logic              ent_last,
   input  logic [2:0]        ent_nbytes,
   output logic              st_enqueue,
   output logic [31:0]       st_wdata,
   output logic [31:0]       st_wdata_nostuff,
   input  logic              st_ready,
   output logic              st_dequeue,
   input  logic [7:0]        st_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_last
);

   localparam int unsigned CW = $clog2(CREDITS + 1);

   seq_state_e        state_q,      state_d;
   logic [HDR_AW:0]   hdr_cnt_q,    hdr_cnt_d;
   logic              hdr_pend_q,   hdr_pend_d;
   logic [CW-1:0]     credit_q,     credit_d;
   logic [1:0]        byte_pos_q,   byte_pos_d;
   logic              stuff_pend_q, stuff_pend_d;

   shadow_t           head;
   logic              fifo_empty;
   logic              retire;
   logic              credit_free;
   logic [3:0]        enq_mask;
   logic              enq_eoi;
   int                in_flight;

   mask_fifo u_mask_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (st_enqueue),
      .wdata ({enq_eoi, enq_mask}),
      .pop   (retire),
      .rdata (head),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      hdr_cnt_d    = hdr_cnt_q;
      hdr_pend_d   = 1'b0;
      byte_pos_d   = byte_pos_q;
      stuff_pend_d = stuff_pend_q;
      hdr_addr     = '0;
      ent_ready    = 1'b0;
      frame_done   = 1'b0;
      st_enqueue   = 1'b0;
      st_wdata     = '0;
      enq_mask     = '0;
      enq_eoi      = 1'b0;

      out_valid  = st_ready;
      out_data   = st_rdata;
      st_dequeue = st_ready & out_ready;

      // A word retires when its 4th real byte leaves; a pending stuffed 0x00
      // is not a real byte.
      retire      = st_dequeue & ~stuff_pend_q & (byte_pos_q == 2'd3) & ~fifo_empty;
      credit_free = (credit_q < CW'(CREDITS)) | retire;
      // Credits the header path must leave room for: the ROM read issued last
      // cycle becomes an enqueue this cycle.
      in_flight   = int'(credit_q) + int'(hdr_pend_q) - int'(retire);

      unique case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               state_d   = ST_HDR;
               hdr_cnt_d = '0;
            end
         end
         ST_HDR: begin
            if (hdr_cnt_q < (HDR_AW+1)'(HDR_WORDS)) begin
               hdr_addr = hdr_cnt_q[HDR_AW-1:0];
               if (in_flight < int'(CREDITS)) begin
                  hdr_pend_d = 1'b1;
                  hdr_cnt_d  = hdr_cnt_q + 1'b1;
               end
            end
            if (hdr_pend_q) begin
               st_enqueue = 1'b1;
               st_wdata   = hdr_data;
               enq_mask   = 4'hF;
               if (hdr_cnt_q == (HDR_AW+1)'(HDR_WORDS)) begin
                  state_d = ST_ENT;
               end
            end
         end
         ST_ENT: begin
            ent_ready = credit_free;
            if (ent_valid && credit_free) begin
               st_enqueue = 1'b1;
               st_wdata   = ent_data;
               // Unused low lanes of a short last word become unstuffed fill.
               for (int i = 0; i < 4; i++) begin
                  if (ent_last && (i >= int'(ent_nbytes))) begin
                     st_wdata[31-8*i -: 8] = FILL_BYTE;
                     enq_mask[i]           = 1'b1;
                  end
               end
               if (ent_last) begin
                  state_d = ST_EOI;
               end
            end
         end
         ST_EOI: begin
            if (credit_free) begin
               st_enqueue = 1'b1;
               st_wdata   = EOI_WORD;
               enq_mask   = 4'hF;
               enq_eoi    = 1'b1;
               state_d    = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (credit_q == '0) begin
               frame_done = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      credit_d = credit_q + CW'(st_enqueue) - CW'(retire);

      // A 0xFF in a stuffable lane is followed by an inserted 0x00 that does
      // not belong to any lane, so byte_pos holds still for it.
      if (st_dequeue) begin
         if (stuff_pend_q) begin
            stuff_pend_d = 1'b0;
         end else begin
            byte_pos_d = byte_pos_q + 2'd1;
            if ((st_rdata == FILL_BYTE) && !head.mask[byte_pos_q]) begin
               stuff_pend_d = 1'b1;
            end
         end
      end

      out_last         = out_valid & ~fifo_empty & head.eoi & (byte_pos_q == 2'd3) & ~stuff_pend_q;
      st_wdata_nostuff = expand_mask(enq_mask);
      busy             = (state_q != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         hdr_cnt_q    <= '0;
         hdr_pend_q   <= 1'b0;
         credit_q     <= '0;
         byte_pos_q   <= '0;
         stuff_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_cnt_q    <= hdr_cnt_d;
         hdr_pend_q   <= hdr_pend_d;
         credit_q     <= credit_d;
         byte_pos_q   <= byte_pos_d;
         stuff_pend_q <= stuff_pend_d;
      end
   end

endmodule
